// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - synchronous FIFO on a dual-port RAM with occupancy, flags and sticky errors
//
// Ports:
//   clk           rising-edge clock
//   reset_L       synchronous active-low reset (RAM contents are not cleared)
//   data_in       word to write
//   push          write request
//   pop           read request
//   data_out      registered read data, one cycle after an accepted pop
//   valid_out     data_out holds a word popped on the previous cycle
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= ALMOST_FULL
//   almost_empty  count <= ALMOST_EMPTY
//   count         current occupancy, 0..DEPTH
//   overflow_err  sticky: a push was rejected
//   underflow_err sticky: a pop was rejected

module fifo_ram #(
  parameter int DATA_BITS    = 8,
  parameter int ADDR_BITS    = 6,
  parameter int ALMOST_FULL  = 2**ADDR_BITS - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 push,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   AF_C    = (ADDR_BITS+1)'(ALMOST_FULL);
  localparam logic [ADDR_BITS:0]   AE_C    = (ADDR_BITS+1)'(ALMOST_EMPTY);
  localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  // Flags come straight from the registered count.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A push into a full FIFO is still accepted when a pop frees a slot in the
  // same cycle; the pop reads rd_ptr before the write lands, so the oldest
  // word leaves. An empty FIFO never bypasses the incoming word to the pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // RAM array has no reset; writes are suppressed during the reset cycle.
  always_ff @(posedge clk) begin
    if (reset_L && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && !push_ok) begin
        overflow_err <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ram.sv
// tb/tb_fifo_ram.sv - self-checking bench for fifo_ram against a queue model

module tb_fifo_ram;

  localparam int DEPTH = 64;
  localparam int AF    = 62;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [6:0] count;
  logic       overflow_err;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  fifo_ram #(
    .DATA_BITS(8),
    .ADDR_BITS(6),
    .ALMOST_FULL(AF),
    .ALMOST_EMPTY(AE)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .data_in(data_in),
    .push(push),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of words plus the sticky flags.
  logic [7:0] q[$];
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  bit         chk_en = 1'b0;
  bit         m_po;
  bit         m_pu;

  always @(posedge clk) begin
    if (!reset_L) begin
      q.delete();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      chk_en  = 1'b1;
    end else begin
      m_po = pop && (q.size() > 0);
      m_pu = push && ((q.size() < DEPTH) || m_po);
      m_valid = m_po;
      if (m_po) m_data = q.pop_front();
      if (m_pu) q.push_back(data_in);
      if (push && !m_pu) m_ovf = 1'b1;
      if (pop && !m_po) m_unf = 1'b1;
    end
  end

  int n;
  always @(negedge clk) begin
    if (chk_en) begin
      n = q.size();
      check("count", 32'(count), 32'(n));
      check("full", 32'(full), 32'(n == DEPTH));
      check("empty", 32'(empty), 32'(n == 0));
      check("almost_full", 32'(almost_full), 32'(n >= AF));
      check("almost_empty", 32'(almost_empty), 32'(n <= AE));
      check("valid_out", 32'(valid_out), 32'(m_valid));
      check("data_out", 32'(data_out), 32'(m_data));
      check("overflow_err", 32'(overflow_err), 32'(m_ovf));
      check("underflow_err", 32'(underflow_err), 32'(m_unf));
    end
  end

  task automatic step(input bit pu, input bit po, input logic [7:0] d);
    push = pu;
    pop = po;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    reset_L = 1'b1;
    step(0, 0, 8'h00);
    check("lit_reset_count", 32'(count), 32'd0);
    check("lit_reset_empty", 32'(empty), 32'd1);
    check("lit_reset_aempty", 32'(almost_empty), 32'd1);
    check("lit_reset_full", 32'(full), 32'd0);
    check("lit_reset_valid", 32'(valid_out), 32'd0);
    check("lit_reset_errs", 32'({overflow_err, underflow_err}), 32'd0);

    // Fill 0x01..0x40
    for (int i = 1; i <= 64; i++) begin
      step(1, 0, 8'(i));
      if (i == 61) check("lit_af_at61", 32'(almost_full), 32'd0);
      if (i == 62) check("lit_af_at62", 32'(almost_full), 32'd1);
    end
    check("lit_full_count", 32'(count), 32'd64);
    check("lit_full_flag", 32'(full), 32'd1);
    step(1, 0, 8'hFF);
    check("lit_ovf", 32'(overflow_err), 32'd1);
    check("lit_ovf_count", 32'(count), 32'd64);

    // Drain: data appears one cycle after each pop
    for (int i = 1; i <= 64; i++) begin
      step(0, 1, 8'h00);
      check("lit_pop_data", 32'(data_out), 32'(i));
      check("lit_pop_valid", 32'(valid_out), 32'd1);
    end
    step(0, 1, 8'h00);
    check("lit_unf", 32'(underflow_err), 32'd1);
    check("lit_unf_valid", 32'(valid_out), 32'd0);
    check("lit_unf_hold", 32'(data_out), 32'h40);
    check("lit_drained_empty", 32'(empty), 32'd1);

    // Wrap-around ordering
    for (int i = 0; i < 40; i++) step(1, 0, 8'(i));
    for (int i = 0; i < 40; i++) step(0, 1, 8'h00);
    for (int i = 40; i < 80; i++) step(1, 0, 8'(i));
    for (int i = 40; i < 80; i++) begin
      step(0, 1, 8'h00);
      check("lit_wrap_data", 32'(data_out), 32'(i));
    end
    step(0, 0, 8'h00);

    // Simultaneous push+pop at count=10
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h80 + i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 8'(8'h90 + i));
      check("lit_sim_count", 32'(count), 32'd10);
    end
    // Simultaneous at full
    for (int i = 0; i < 54; i++) step(1, 0, 8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'(8'hE0 + i));
      check("lit_simfull_count", 32'(count), 32'd64);
    end
    for (int i = 0; i < 64; i++) step(0, 1, 8'h00);
    // Fresh reset clears sticky flags before the empty-case check
    reset_L = 1'b0;
    step(0, 0, 8'h00);
    reset_L = 1'b1;
    step(1, 1, 8'h77);
    check("lit_simempty_count", 32'(count), 32'd1);
    check("lit_simempty_unf", 32'(underflow_err), 32'd1);
    check("lit_simempty_valid", 32'(valid_out), 32'd0);

    // Reset mid-stream with push asserted
    for (int i = 0; i < 29; i++) step(1, 0, 8'(8'h10 + i));
    check("lit_pre_rst_count", 32'(count), 32'd30);
    reset_L = 1'b0;
    step(1, 0, 8'h55);
    reset_L = 1'b1;
    check("lit_rst_count", 32'(count), 32'd0);
    check("lit_rst_empty", 32'(empty), 32'd1);
    check("lit_rst_errs", 32'({overflow_err, underflow_err}), 32'd0);
    step(1, 0, 8'hA5);
    step(0, 1, 8'h00);
    check("lit_fresh_data", 32'(data_out), 32'hA5);
    check("lit_fresh_valid", 32'(valid_out), 32'd1);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
